// File: rtl/sum_uart_pkg.sv
// Shared types and sizing helpers for the sum/UART streamer.
package sum_uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // start + 8 data + stop, plus the optional parity bit
  function automatic int unsigned frame_bits(input int unsigned parity_en);
    return 10 + parity_en;
  endfunction

  // Sizing for the default 16-bit accumulator, 8N1 build.
  localparam int unsigned NBYTES     = ceil_div(16, BYTE_W);
  localparam int unsigned FRAME_BITS = frame_bits(0);

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// done_o marks the edge that ends the stop bit; a start_i on that edge chains the next byte.
module uart_tx_byte
  import sum_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 5208,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       done_o
);

  localparam int unsigned CntW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t CntLoad = cnt_t'(BAUD_DIV - 1);

  tx_state_e  state_q;
  cnt_t       cnt_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       par_q;
  logic       tx_q;
  logic       bit_end;

  assign bit_end = (cnt_q == '0);
  assign done_o  = (state_q == StStop) && bit_end;
  assign tx_o    = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else if (state_q != StIdle && !bit_end) begin
      cnt_q <= cnt_q - 1'b1;
    end else begin
      // Every bit period begins with a fresh load, so each state lasts BAUD_DIV cycles.
      cnt_q <= CntLoad;
      unique case (state_q)
        StIdle, StStop: begin
          if (start_i) begin
            state_q <= StStart;
            shift_q <= data_i;
            par_q   <= (^data_i) ^ 1'(PARITY_ODD);
            tx_q    <= 1'b0;
          end else begin
            state_q <= StIdle;
            tx_q    <= 1'b1;
          end
        end
        StStart: begin
          state_q <= StData;
          bit_q   <= '0;
          tx_q    <= shift_q[0];
        end
        StData: begin
          if (bit_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_q <= StParity;
              tx_q    <= par_q;
            end else begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end
          end else begin
            bit_q   <= bit_q + 1'b1;
            shift_q <= shift_q >> 1;
            tx_q    <= shift_q[1];
          end
        end
        StParity: begin
          state_q <= StStop;
          tx_q    <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/sum_uart_streamer.sv
// Running-sum accumulator with a snapshot register that is streamed out over UART,
// least significant byte first.
module sum_uart_streamer
  import sum_uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned BAUD_DIV   = 5208,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  input  logic              clear_i,
  input  logic              send_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic [ACC_W-1:0]  sum_out_o,
  output logic              overflow_o
);

  localparam int unsigned NBytes = ceil_div(ACC_W, BYTE_W);
  localparam int unsigned PadW   = NBytes * BYTE_W;
  localparam int unsigned SumW   = ACC_W + 1;
  localparam int unsigned RemW   = (NBytes > 1) ? $clog2(NBytes) : 1;

  logic [ACC_W-1:0] sum_q;
  logic             ovf_q;
  logic [PadW-1:0]  snap_q;
  logic [RemW-1:0]  rem_q;
  logic             send_q;
  logic             busy_q;

  logic [SumW-1:0]  sum_ext;
  logic [PadW-1:0]  sum_pad;
  logic             add_en;
  logic             send_ok;
  logic             byte_done;
  logic             byte_start;

  assign in_ready_o = ena_i & ~clear_i;
  assign add_en     = in_valid_i & in_ready_o;
  assign sum_ext    = {1'b0, sum_q} + SumW'(in_data_i);
  assign sum_pad    = PadW'(sum_q);
  // send_q covers the cycle between acceptance and busy rising.
  assign send_ok    = send_i & ena_i & ~busy_q & ~send_q;
  assign byte_start = send_q | (busy_q & byte_done & (rem_q != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear_i) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (add_en) begin
      sum_q <= sum_ext[ACC_W-1:0];
      if (sum_ext[ACC_W]) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Byte sequencer: snap_q[7:0] always holds the byte to hand to the transmitter next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
      rem_q  <= '0;
      send_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      send_q <= send_ok;
      if (send_ok) begin
        snap_q <= sum_pad;
      end else if (send_q) begin
        busy_q <= 1'b1;
        rem_q  <= RemW'(NBytes - 1);
        snap_q <= snap_q >> BYTE_W;
      end else if (busy_q && byte_done) begin
        if (rem_q == '0) begin
          busy_q <= 1'b0;
        end else begin
          rem_q  <= rem_q - 1'b1;
          snap_q <= snap_q >> BYTE_W;
        end
      end
    end
  end

  uart_tx_byte #(
    .BAUD_DIV  (BAUD_DIV),
    .PARITY_EN (PARITY_EN),
    .PARITY_ODD(PARITY_ODD)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(byte_start),
    .data_i (snap_q[7:0]),
    .tx_o   (tx_o),
    .done_o (byte_done)
  );

  assign busy_o     = busy_q;
  assign sum_out_o  = sum_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_sum_uart_streamer.sv
// Directed bench: four streamer builds share stimulus; tx/busy histories are decoded per cycle.
module tb_sum_uart_streamer;

  localparam int Baud  = 4;
  localparam int HistN = 2048;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ena      = 1'b0;
  logic       in_valid = 1'b0;
  logic       clear    = 1'b0;
  logic       send     = 1'b0;
  logic [7:0] in_data  = 8'h00;

  logic [3:0]  tx, busy, rdy, ovf;
  logic [15:0] sum16, sum_pe, sum_po;
  logic [7:0]  sum8;

  int   cyc = 0;
  logic tx_h   [4][HistN];
  logic busy_h [4][HistN];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < HistN) begin
      for (int d = 0; d < 4; d++) begin
        tx_h[d][cyc]   = tx[d];
        busy_h[d][cyc] = busy[d];
      end
    end
  end

  sum_uart_streamer #(.DATA_W(8), .ACC_W(16), .BAUD_DIV(Baud), .PARITY_EN(0), .PARITY_ODD(0))
  u_dut16 (
    .clk(clk), .rst_n(rst_n), .ena_i(ena), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(rdy[0]), .clear_i(clear), .send_i(send), .tx_o(tx[0]), .busy_o(busy[0]),
    .sum_out_o(sum16), .overflow_o(ovf[0])
  );

  sum_uart_streamer #(.DATA_W(8), .ACC_W(8), .BAUD_DIV(Baud), .PARITY_EN(0), .PARITY_ODD(0))
  u_dut8 (
    .clk(clk), .rst_n(rst_n), .ena_i(ena), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(rdy[1]), .clear_i(clear), .send_i(send), .tx_o(tx[1]), .busy_o(busy[1]),
    .sum_out_o(sum8), .overflow_o(ovf[1])
  );

  sum_uart_streamer #(.DATA_W(8), .ACC_W(16), .BAUD_DIV(Baud), .PARITY_EN(1), .PARITY_ODD(0))
  u_dut_pe (
    .clk(clk), .rst_n(rst_n), .ena_i(ena), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(rdy[2]), .clear_i(clear), .send_i(send), .tx_o(tx[2]), .busy_o(busy[2]),
    .sum_out_o(sum_pe), .overflow_o(ovf[2])
  );

  sum_uart_streamer #(.DATA_W(8), .ACC_W(16), .BAUD_DIV(Baud), .PARITY_EN(1), .PARITY_ODD(1))
  u_dut_po (
    .clk(clk), .rst_n(rst_n), .ena_i(ena), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(rdy[3]), .clear_i(clear), .send_i(send), .tx_o(tx[3]), .busy_o(busy[3]),
    .sum_out_o(sum_po), .overflow_o(ovf[3])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k is the edge that sampled send; the start bit occupies the Baud cycles after edge k+1.
  task automatic check_frame(input string tag, input int d, input int k, input int bidx,
                             input int fb, input logic [7:0] exp_byte, input logic exp_par);
    int         base;
    logic [7:0] b;
    base = k + 1 + bidx * fb * Baud + Baud / 2;
    check_eq({tag, ".start"}, 32'(tx_h[d][base]), 32'd0);
    for (int i = 0; i < 8; i++) b[i] = tx_h[d][base + (i + 1) * Baud];
    check_eq({tag, ".data"}, 32'(b), 32'(exp_byte));
    if (fb == 11) check_eq({tag, ".par"}, 32'(tx_h[d][base + 9 * Baud]), 32'(exp_par));
    check_eq({tag, ".stop"}, 32'(tx_h[d][base + (fb - 1) * Baud]), 32'd1);
  endtask

  task automatic check_busy(input string tag, input int d, input int k, input int n);
    int cnt;
    int rises;
    cnt   = 0;
    rises = 0;
    for (int i = k; i < k + n + 10; i++) begin
      if (busy_h[d][i] === 1'b1) cnt++;
      if (i > k && busy_h[d][i] === 1'b1 && busy_h[d][i-1] === 1'b0) rises++;
    end
    check_eq({tag, ".lat"}, 32'(busy_h[d][k+1]), 32'd1);
    check_eq({tag, ".cycles"}, 32'(cnt), 32'(n));
    check_eq({tag, ".rises"}, 32'(rises), 32'd1);
  endtask

  initial begin
    int k;

    // 1. reset and idle
    repeat (3) tick();
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (20) tick();
    for (int d = 0; d < 4; d++) begin
      check_eq($sformatf("idle.tx%0d", d), 32'(tx[d]), 32'd1);
      check_eq($sformatf("idle.busy%0d", d), 32'(busy[d]), 32'd0);
    end
    check_eq("idle.sum16", 32'(sum16), 32'd0);
    check_eq("idle.sum8", 32'(sum8), 32'd0);
    check_eq("idle.ovf", 32'(ovf), 32'd0);

    // 2 + 5. accumulate 0x12 + 0x34, send, then add and re-send while busy
    in_valid = 1'b1;
    in_data  = 8'h12;
    tick();
    in_data = 8'h34;
    tick();
    in_valid = 1'b0;
    check_eq("acc.sum16", 32'(sum16), 32'h46);
    send = 1'b1;
    tick();
    k    = cyc;
    send = 1'b0;
    repeat (5) tick();
    in_valid = 1'b1;
    in_data  = 8'h01;
    send     = 1'b1;
    tick();
    in_valid = 1'b0;
    send     = 1'b0;
    repeat (100) tick();
    check_eq("busy_add.sum16", 32'(sum16), 32'h47);
    check_frame("s46.b0", 0, k, 0, 10, 8'h46, 1'b0);
    check_frame("s46.b1", 0, k, 1, 10, 8'h00, 1'b0);
    check_busy("s46.d16", 0, k, 80);
    check_frame("s46.acc8", 1, k, 0, 10, 8'h46, 1'b0);
    check_busy("s46.acc8", 1, k, 40);
    check_frame("s46.even", 2, k, 0, 11, 8'h46, 1'b1);
    check_frame("s46.odd", 3, k, 0, 11, 8'h46, 1'b0);
    check_busy("s46.par", 2, k, 88);

    // 4. parity on snapshot 0x07
    clear = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h07;
    tick();
    in_valid = 1'b0;
    send     = 1'b1;
    tick();
    k    = cyc;
    send = 1'b0;
    repeat (100) tick();
    check_frame("s07.even.b0", 2, k, 0, 11, 8'h07, 1'b1);
    check_frame("s07.even.b1", 2, k, 1, 11, 8'h00, 1'b0);
    check_frame("s07.odd.b0", 3, k, 0, 11, 8'h07, 1'b0);
    check_frame("s07.odd.b1", 3, k, 1, 11, 8'h00, 1'b1);
    check_busy("s07.even", 2, k, 88);

    // 3. overflow and clear priority
    clear = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hF0;
    tick();
    in_data = 8'h20;
    tick();
    in_valid = 1'b0;
    check_eq("ovf.sum8", 32'(sum8), 32'h10);
    check_eq("ovf.flag8", 32'(ovf[1]), 32'd1);
    check_eq("ovf.sum16", 32'(sum16), 32'h110);
    check_eq("ovf.flag16", 32'(ovf[0]), 32'd0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h05;
    #1;
    check_eq("clr.in_ready", 32'(rdy[0]), 32'd0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check_eq("clr.sum8", 32'(sum8), 32'd0);
    check_eq("clr.flag8", 32'(ovf[1]), 32'd0);
    check_eq("clr.sum16", 32'(sum16), 32'd0);

    // ena low blocks operands and sends
    ena      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h03;
    send     = 1'b1;
    #1;
    check_eq("ena0.in_ready", 32'(rdy[0]), 32'd0);
    tick();
    in_valid = 1'b0;
    send     = 1'b0;
    repeat (2) tick();
    check_eq("ena0.sum16", 32'(sum16), 32'd0);
    check_eq("ena0.busy", 32'(busy[0]), 32'd0);
    ena = 1'b1;

    // 6. asynchronous reset during data bit 3, then a normal send
    in_valid = 1'b1;
    in_data  = 8'h46;
    tick();
    in_valid = 1'b0;
    send     = 1'b1;
    tick();
    k    = cyc;
    send = 1'b0;
    for (int i = 0; i < 100 && cyc < k + 18; i++) tick();
    check_eq("rst.pre_tx", 32'(tx[0]), 32'd0);
    check_eq("rst.pre_busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst.tx", 32'(tx[0]), 32'd1);
    check_eq("rst.busy", 32'(busy[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    send     = 1'b1;
    tick();
    k    = cyc;
    send = 1'b0;
    repeat (100) tick();
    check_frame("post_rst.b0", 0, k, 0, 10, 8'h5A, 1'b0);
    check_frame("post_rst.b1", 0, k, 1, 10, 8'h00, 1'b0);
    check_busy("post_rst", 0, k, 80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
